game_score_tracker: RTL and testbench
=====================================

Name: game_score_tracker

Overview:
- Tracks the score for the multi-mode counter game, on the opposite side of the flags controller.
- Consumes the level WINNER/LOSER flags and produces the W_count/L_count tallies that the flags controller reads.
- Runs the match lifecycle PLAY -> OVER -> CLEAR: detects the end of a game, holds the result for a minimum time, then clears scores and requests a counter reload.

Parameters:
- MAX_SCORE, 15: tally value that ends a game. Range 1..15; tallies are 4 bits.
- HOLD_CYCLES, 8: minimum number of dclk cycles spent in OVER before a restart is accepted. Must be >= 1.
- ROUND_W, 8: width of the completed-games counter.

Ports:
- dclk  input  1  single clock; all logic on the rising edge.
- arstn  input  1  reset, asynchronous, active-low.
- winner_i  input  1  level WINNER flag from the flags controller.
- loser_i  input  1  level LOSER flag from the flags controller.
- restart_i  input  1  restart request, sampled each cycle.
- w_count  output  4  win tally.
- l_count  output  4  loss tally.
- game_over  output  1  high while in OVER.
- who  output  2  result code: 00 none, 10 player won, 01 player lost, 11 tie.
- load_req  output  1  one-cycle pulse asking the counter to reload its initial value.
- rounds  output  ROUND_W  number of completed games.

Behaviour:
- Reset (arstn low, async):
  - State = PLAY.
  - w_count, l_count, rounds, hold counter, win_prev, lose_prev = 0.
  - game_over = 0, who = 00, load_req = 0.
  - Outputs take these values immediately on reset assertion, without waiting for a clock edge.
- Edge detect:
  - win_prev/lose_prev register winner_i/loser_i every cycle in every state.
  - win_ev = winner_i & ~win_prev; lose_ev = loser_i & ~lose_prev.
  - A level held high counts exactly once. A level held across CLEAR does not re-count.
- PLAY:
  - win_ev increments w_count; lose_ev increments l_count.
  - Both events in the same cycle increment both.
  - Tallies saturate at MAX_SCORE and never wrap.
  - Go to OVER when the updated w_count or l_count equals MAX_SCORE. The tally update and the state change happen on the same edge.
  - On the transition to OVER: rounds += 1 (wraps modulo 2^ROUND_W) and the hold counter loads HOLD_CYCLES.
  - who is latched on the transition: 10 if w_count hit MAX, 01 if l_count hit MAX, 11 if both hit MAX on the same edge.
  - restart_i high in PLAY aborts the game: go to CLEAR, with no rounds increment.
  - Within a cycle, reaching MAX takes priority over restart_i: the game goes to OVER.
- OVER:
  - game_over = 1 and who holds its latched value.
  - Tallies are frozen; win_ev/lose_ev are ignored.
  - The hold counter decrements each cycle down to 0.
  - Go to CLEAR when restart_i = 1 and the hold counter = 0. restart_i while the counter is nonzero is ignored; the request is not stored.
- CLEAR (exactly 1 cycle):
  - w_count = l_count = 0, who = 00, game_over = 0, load_req = 1.
  - Next state is PLAY unconditionally.
  - Events arriving in the CLEAR cycle are dropped.
- Outputs:
  - All outputs are registered.
  - game_over is high for the cycles the FSM is in OVER, i.e. from the edge after the final scoring event.
  - load_req is high only during CLEAR.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-game: w_count = 5, l_count = 3, then arstn low between edges -> all outputs 0 immediately, before the next dclk edge; state PLAY after release.
- Win game: 15 separate winner_i pulses (each 2 cycles high, 2 low) -> w_count steps 1..15; game_over = 1 and who = 10 on the edge of the 15th pulse; rounds = 1.
- Held level: winner_i held high for 20 cycles -> w_count = 1 only; l_count unchanged.
- Hold enforcement: restart_i pulsed on OVER cycle 3 (HOLD_CYCLES = 8) -> remains in OVER. restart_i on cycle 9 -> one cycle with load_req = 1 and tallies 0, then PLAY; rounds stays 1.
- Simultaneous events: w_count = 14, l_count = 14, winner_i and loser_i rise on the same cycle -> both 15, who = 11, game_over = 1.
- Abort and saturation: restart_i in PLAY with w_count = 7 -> CLEAR, load_req pulse, rounds unchanged. Win and loss events arriving during OVER and CLEAR -> tallies never exceed 15 or change.

Source files
------------

// File: rtl/game_score_tracker_if.sv
// Flag inputs and score/result outputs shared between the score tracker and
// its environment.
interface game_score_tracker_if #(
  parameter int ROUND_W = 8
);
  logic               winner_i;
  logic               loser_i;
  logic               restart_i;
  logic [3:0]         w_count;
  logic [3:0]         l_count;
  logic               game_over;
  logic [1:0]         who;
  logic               load_req;
  logic [ROUND_W-1:0] rounds;

  modport master (
    output winner_i, loser_i, restart_i,
    input  w_count, l_count, game_over, who, load_req, rounds
  );

  modport slave (
    input  winner_i, loser_i, restart_i,
    output w_count, l_count, game_over, who, load_req, rounds
  );
endinterface

// File: rtl/game_score_tracker.sv
// Win/loss tally and match lifecycle (PLAY -> OVER -> CLEAR) for the counter game.
//   state   | meaning
//   S_PLAY  | counting rising edges of winner/loser flags
//   S_OVER  | result held, tallies frozen, hold timer running
//   S_CLEAR | one cycle: tallies zeroed, counter reload requested
module game_score_tracker #(
  parameter int MAX_SCORE   = 15,
  parameter int HOLD_CYCLES = 8,
  parameter int ROUND_W     = 8
) (
  input  logic                 dclk,
  input  logic                 arstn,
  game_score_tracker_if.slave  bus
);

  localparam int         HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0] MAX_V  = 4'(MAX_SCORE);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_OVER  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [3:0]          w_q, w_n, l_q, l_n;
  logic [1:0]          who_q, who_n;
  logic [ROUND_W-1:0]  rounds_q, rounds_n;
  logic [HOLD_W-1:0]   hold_q, hold_n;
  logic                go_q, go_n, lr_q, lr_n;
  logic                win_prev, lose_prev;
  logic                win_ev, lose_ev;

  assign win_ev  = bus.winner_i & ~win_prev;
  assign lose_ev = bus.loser_i  & ~lose_prev;

  always_ff @(posedge dclk or negedge arstn) begin
    if (!arstn) begin
      state     <= S_PLAY;
      w_q       <= '0;
      l_q       <= '0;
      who_q     <= '0;
      rounds_q  <= '0;
      hold_q    <= '0;
      go_q      <= 1'b0;
      lr_q      <= 1'b0;
      win_prev  <= 1'b0;
      lose_prev <= 1'b0;
    end else begin
      state     <= state_n;
      w_q       <= w_n;
      l_q       <= l_n;
      who_q     <= who_n;
      rounds_q  <= rounds_n;
      hold_q    <= hold_n;
      go_q      <= go_n;
      lr_q      <= lr_n;
      win_prev  <= bus.winner_i;
      lose_prev <= bus.loser_i;
    end
  end

  always_comb begin
    state_n  = state;
    w_n      = w_q;
    l_n      = l_q;
    who_n    = who_q;
    rounds_n = rounds_q;
    hold_n   = hold_q;
    case (state)
      S_PLAY: begin
        if (win_ev  && (w_q < MAX_V)) w_n = w_q + 4'd1;
        if (lose_ev && (l_q < MAX_V)) l_n = l_q + 4'd1;
        // Reaching MAX wins over a same-cycle restart request.
        if ((w_n == MAX_V) || (l_n == MAX_V)) begin
          state_n  = S_OVER;
          rounds_n = rounds_q + 1'b1;
          hold_n   = HOLD_W'(HOLD_CYCLES);
          who_n    = {w_n == MAX_V, l_n == MAX_V};
        end else if (bus.restart_i) begin
          state_n = S_CLEAR;
          w_n     = '0;
          l_n     = '0;
          who_n   = '0;
        end
      end
      S_OVER: begin
        if (hold_q != '0) hold_n = hold_q - 1'b1;
        if (bus.restart_i && (hold_q == '0)) begin
          state_n = S_CLEAR;
          w_n     = '0;
          l_n     = '0;
          who_n   = '0;
        end
      end
      S_CLEAR: begin
        state_n = S_PLAY;
      end
      default: begin
        state_n = S_PLAY;
      end
    endcase
    go_n = (state_n == S_OVER);
    lr_n = (state_n == S_CLEAR);
  end

  assign bus.w_count   = w_q;
  assign bus.l_count   = l_q;
  assign bus.who       = who_q;
  assign bus.rounds    = rounds_q;
  assign bus.game_over = go_q;
  assign bus.load_req  = lr_q;

endmodule

// File: tb/tb_game_score_tracker.sv
// Directed bench for game_score_tracker: reset, scoring, hold timer, abort, priority.
module tb_game_score_tracker;

  logic dclk;
  logic arstn;
  int   checks;
  int   errors;

  game_score_tracker_if #(.ROUND_W(8)) bus ();

  game_score_tracker #(
    .MAX_SCORE   (15),
    .HOLD_CYCLES (8),
    .ROUND_W     (8)
  ) dut (
    .dclk  (dclk),
    .arstn (arstn),
    .bus   (bus.slave)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge dclk);
      #1;
    end
  endtask

  // Rising edge on the given flags, 2 cycles high, 2 cycles low.
  task automatic pulse(input logic w, input logic l);
    bus.winner_i = w;
    bus.loser_i  = l;
    tick(2);
    bus.winner_i = 1'b0;
    bus.loser_i  = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.w_count, bus.l_count, bus.game_over, bus.who, bus.load_req, bus.rounds} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got w=%0d l=%0d go=%0b who=%b lr=%0b rounds=%0d want all 0",
               bus.w_count, bus.l_count, bus.game_over, bus.who, bus.load_req, bus.rounds);
    end
    tick(2);
    arstn = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_mid_game;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.w_count !== 4'd5 || bus.l_count !== 4'd3) begin
      errors++;
      $display("FAIL mid_tallies got w=%0d l=%0d want w=5 l=3", bus.w_count, bus.l_count);
    end
    #3 arstn = 1'b0;
    #1;
    checks++;
    if ({bus.w_count, bus.l_count, bus.game_over, bus.who, bus.load_req, bus.rounds} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got w=%0d l=%0d go=%0b who=%b lr=%0b want all 0",
               bus.w_count, bus.l_count, bus.game_over, bus.who, bus.load_req);
    end
    tick(1);
    arstn = 1'b1;
    bus.winner_i = 1'b1;
    tick(1);
    checks++;
    if (bus.w_count !== 4'd1 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL play_after_reset got w=%0d go=%0b want w=1 go=0", bus.w_count, bus.game_over);
    end
    bus.winner_i = 1'b0;
    tick(1);
    arstn = 1'b0;
    tick(1);
    arstn = 1'b1;
    tick(1);
  endtask

  task automatic test_win_game_and_hold;
    for (int i = 1; i <= 15; i++) begin
      bus.winner_i = 1'b1;
      tick(1);
      checks++;
      if (bus.w_count !== 4'(i)) begin
        errors++;
        $display("FAIL win_step got w=%0d want %0d", bus.w_count, i);
      end
      if (i < 15) begin
        tick(1);
        bus.winner_i = 1'b0;
        tick(2);
      end
    end
    bus.winner_i = 1'b0;
    checks++;
    if (bus.game_over !== 1'b1 || bus.who !== 2'b10 || bus.rounds !== 8'd1) begin
      errors++;
      $display("FAIL win_over got go=%0b who=%b rounds=%0d want go=1 who=10 rounds=1",
               bus.game_over, bus.who, bus.rounds);
    end
    // OVER cycle 1: a loss event must be ignored.
    bus.loser_i = 1'b1;
    tick(1);
    checks++;
    if (bus.l_count !== 4'd0 || bus.w_count !== 4'd15) begin
      errors++;
      $display("FAIL over_frozen got w=%0d l=%0d want w=15 l=0", bus.w_count, bus.l_count);
    end
    bus.loser_i = 1'b0;
    tick(1);
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    checks++;
    if (bus.game_over !== 1'b1 || bus.load_req !== 1'b0) begin
      errors++;
      $display("FAIL early_restart got go=%0b lr=%0b want go=1 lr=0", bus.game_over, bus.load_req);
    end
    tick(5);
    checks++;
    if (bus.game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_cycle9 got go=%0b want 1", bus.game_over);
    end
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    checks++;
    if (bus.load_req !== 1'b1 || bus.w_count !== 4'd0 || bus.l_count !== 4'd0 ||
        bus.who !== 2'b00 || bus.game_over !== 1'b0 || bus.rounds !== 8'd1) begin
      errors++;
      $display("FAIL clear_cycle got lr=%0b w=%0d l=%0d who=%b go=%0b rounds=%0d want 1 0 0 00 0 1",
               bus.load_req, bus.w_count, bus.l_count, bus.who, bus.game_over, bus.rounds);
    end
    bus.winner_i = 1'b1;
    tick(1);
    checks++;
    if (bus.load_req !== 1'b0 || bus.w_count !== 4'd0) begin
      errors++;
      $display("FAIL clear_drop got lr=%0b w=%0d want lr=0 w=0", bus.load_req, bus.w_count);
    end
    bus.winner_i = 1'b0;
    tick(2);
  endtask

  task automatic test_held_level;
    bus.winner_i = 1'b1;
    tick(20);
    bus.winner_i = 1'b0;
    checks++;
    if (bus.w_count !== 4'd1 || bus.l_count !== 4'd0) begin
      errors++;
      $display("FAIL held_level got w=%0d l=%0d want w=1 l=0", bus.w_count, bus.l_count);
    end
    tick(1);
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 13; i++) pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.w_count !== 4'd14 || bus.l_count !== 4'd14) begin
      errors++;
      $display("FAIL pre_tie got w=%0d l=%0d want 14 14", bus.w_count, bus.l_count);
    end
    bus.winner_i = 1'b1;
    bus.loser_i  = 1'b1;
    tick(1);
    checks++;
    if (bus.w_count !== 4'd15 || bus.l_count !== 4'd15 || bus.who !== 2'b11 ||
        bus.game_over !== 1'b1 || bus.rounds !== 8'd2) begin
      errors++;
      $display("FAIL tie got w=%0d l=%0d who=%b go=%0b rounds=%0d want 15 15 11 1 2",
               bus.w_count, bus.l_count, bus.who, bus.game_over, bus.rounds);
    end
    // Restart held from OVER cycle 1; only accepted once the hold timer expires.
    bus.restart_i = 1'b1;
    bus.winner_i  = 1'b0;
    bus.loser_i   = 1'b0;
    tick(1);
    bus.winner_i  = 1'b1;
    bus.loser_i   = 1'b1;
    tick(1);
    checks++;
    if (bus.w_count !== 4'd15 || bus.l_count !== 4'd15) begin
      errors++;
      $display("FAIL saturate got w=%0d l=%0d want 15 15", bus.w_count, bus.l_count);
    end
    tick(6);
    checks++;
    if (bus.game_over !== 1'b1 || bus.load_req !== 1'b0) begin
      errors++;
      $display("FAIL tie_hold got go=%0b lr=%0b want go=1 lr=0", bus.game_over, bus.load_req);
    end
    tick(1);
    bus.restart_i = 1'b0;
    checks++;
    if (bus.load_req !== 1'b1 || bus.w_count !== 4'd0 || bus.l_count !== 4'd0) begin
      errors++;
      $display("FAIL tie_clear got lr=%0b w=%0d l=%0d want 1 0 0", bus.load_req, bus.w_count, bus.l_count);
    end
    bus.winner_i = 1'b0;
    bus.loser_i  = 1'b0;
    tick(2);
  endtask

  task automatic test_abort;
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
    checks++;
    if (bus.w_count !== 4'd7) begin
      errors++;
      $display("FAIL abort_pre got w=%0d want 7", bus.w_count);
    end
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    checks++;
    if (bus.load_req !== 1'b1 || bus.w_count !== 4'd0 || bus.rounds !== 8'd2 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL abort got lr=%0b w=%0d rounds=%0d go=%0b want 1 0 2 0",
               bus.load_req, bus.w_count, bus.rounds, bus.game_over);
    end
    tick(1);
    checks++;
    if (bus.load_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse got lr=%0b want 0", bus.load_req);
    end
  endtask

  task automatic test_max_over_restart;
    for (int i = 0; i < 14; i++) pulse(1'b1, 1'b0);
    bus.winner_i  = 1'b1;
    bus.restart_i = 1'b1;
    tick(1);
    bus.winner_i  = 1'b0;
    bus.restart_i = 1'b0;
    checks++;
    if (bus.game_over !== 1'b1 || bus.who !== 2'b10 || bus.load_req !== 1'b0 || bus.rounds !== 8'd3) begin
      errors++;
      $display("FAIL max_priority got go=%0b who=%b lr=%0b rounds=%0d want 1 10 0 3",
               bus.game_over, bus.who, bus.load_req, bus.rounds);
    end
    tick(2);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    arstn         = 1'b0;
    bus.winner_i  = 1'b0;
    bus.loser_i   = 1'b0;
    bus.restart_i = 1'b0;
    #1;
    test_reset;
    test_reset_mid_game;
    test_win_game_and_hold;
    test_held_level;
    test_simultaneous;
    test_abort;
    test_max_over_restart;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
